// File: rtl/pong_pkg.sv
// Shared types and default constants for the pong scoring logic.
package pong_pkg;

  typedef enum logic [1:0] {
    PLAY  = 2'd0,
    POINT = 2'd1,
    PAUSE = 2'd2,
    OVER  = 2'd3
  } state_e;

  typedef enum logic {
    P1 = 1'b0,
    P2 = 1'b1
  } player_e;

  typedef logic [3:0] score_t;

  localparam int unsigned WIN_SCORE     = 7;
  localparam int unsigned RESTART_PAUSE = 128;

endpackage

// File: rtl/row_monitor.sv
// Captures per-frame seen/hit flags for the ball on one paddle row.
module row_monitor #(
  parameter int ROW = 0
) (
  input  logic              clk_i,
  input  logic              rst_ni,
  input  logic              enable_i,
  input  logic              fsync_i,
  input  logic signed [11:0] vpos_i,
  input  logic              active_obj_i,
  input  logic              active_paddle_i,
  output logic              seen_o,
  output logic              hit_o
);

  logic seen_q, seen_d;
  logic hit_q, hit_d;

  // Flags are sticky within a frame; fsync or leaving PLAY discards them.
  always_comb begin
    seen_d = seen_q;
    hit_d  = hit_q;
    if (!enable_i || fsync_i) begin
      seen_d = 1'b0;
      hit_d  = 1'b0;
    end else if ((vpos_i == 12'(ROW)) && active_obj_i) begin
      seen_d = 1'b1;
      if (active_paddle_i) hit_d = 1'b1;
    end
  end

  always_ff @(posedge clk_i) begin
    if (!rst_ni) begin
      seen_q <= 1'b0;
      hit_q  <= 1'b0;
    end else begin
      seen_q <= seen_d;
      hit_q  <= hit_d;
    end
  end

  assign seen_o = seen_q;
  assign hit_o  = hit_q;

endmodule

// File: rtl/point_judge.sv
// Judges missed balls per frame, drives score pulses and round/game pauses.
// POINT_JUDGE_WIN_LIMIT_EN enables the game-over win limit.
module point_judge
  import pong_pkg::*;
#(
  parameter int VRES          = 720,
  parameter int PADDLE_H      = 20,
  parameter int WIN_SCORE     = pong_pkg::WIN_SCORE,
  parameter int RESTART_PAUSE = pong_pkg::RESTART_PAUSE
) (
  input  logic               pixel_clk,
  input  logic               rst_n,
  input  logic               fsync,
  input  logic signed [11:0] vpos,
  input  logic               active_obj,
  input  logic               active_paddle_p1,
  input  logic               active_paddle_p2,
  output logic [1:0]         increment_score,
  output logic               round_reset,
  output logic               game_over,
  output logic               winner,
  output logic [3:0]         score_p1,
  output logic [3:0]         score_p2
);

  if (RESTART_PAUSE < 1 || RESTART_PAUSE > 255) begin : g_bad_pause
    $error("point_judge: RESTART_PAUSE must be within 1..255");
  end
  if (WIN_SCORE < 1 || WIN_SCORE > 15) begin : g_bad_win
    $error("point_judge: WIN_SCORE must be within 1..15");
  end

  localparam logic [7:0] PAUSE_LAST = 8'(RESTART_PAUSE - 1);

  state_e     state_q, state_d;
  player_e    scorer_q, scorer_d;
  player_e    winner_q, winner_d;
  logic [7:0] cnt_q, cnt_d;
  score_t     s1_q, s1_d, s2_q, s2_d;
  logic [1:0] inc_q, inc_d;
  logic       bot_seen, bot_hit, top_seen, top_hit;
  logic       miss_bot, miss_top, in_play;

  assign in_play = (state_q == PLAY);

  row_monitor #(.ROW(VRES - PADDLE_H)) u_bot (
    .clk_i(pixel_clk), .rst_ni(rst_n), .enable_i(in_play), .fsync_i(fsync),
    .vpos_i(vpos), .active_obj_i(active_obj), .active_paddle_i(active_paddle_p1),
    .seen_o(bot_seen), .hit_o(bot_hit)
  );

  row_monitor #(.ROW(PADDLE_H - 1)) u_top (
    .clk_i(pixel_clk), .rst_ni(rst_n), .enable_i(in_play), .fsync_i(fsync),
    .vpos_i(vpos), .active_obj_i(active_obj), .active_paddle_i(active_paddle_p2),
    .seen_o(top_seen), .hit_o(top_hit)
  );

  assign miss_bot = bot_seen & ~bot_hit;
  assign miss_top = top_seen & ~top_hit;

  always_comb begin
    state_d  = state_q;
    scorer_d = scorer_q;
    winner_d = winner_q;
    cnt_d    = cnt_q;
    s1_d     = s1_q;
    s2_d     = s2_q;
    inc_d    = '0;
    unique case (state_q)
      PLAY: begin
        if (fsync) begin
          if (miss_bot && miss_top) begin
            state_d = PAUSE;
            cnt_d   = '0;
          end else if (miss_bot) begin
            state_d  = POINT;
            scorer_d = P2;
          end else if (miss_top) begin
            state_d  = POINT;
            scorer_d = P1;
          end
        end
      end
      POINT: begin
        if (scorer_q == P1) begin
          inc_d = 2'b01;
          s1_d  = s1_q + 4'd1;
        end else begin
          inc_d = 2'b10;
          s2_d  = s2_q + 4'd1;
        end
        state_d = PAUSE;
        cnt_d   = '0;
`ifdef POINT_JUDGE_WIN_LIMIT_EN
        if (((scorer_q == P1) ? s1_d : s2_d) == 4'(WIN_SCORE)) begin
          state_d  = OVER;
          winner_d = scorer_q;
        end
`endif
      end
      PAUSE, OVER: begin
        if (fsync) begin
          if (cnt_q == PAUSE_LAST) begin
            state_d = PLAY;
            cnt_d   = '0;
`ifdef POINT_JUDGE_WIN_LIMIT_EN
            if (state_q == OVER) begin
              s1_d = '0;
              s2_d = '0;
            end
`endif
          end else begin
            cnt_d = cnt_q + 8'd1;
          end
        end
      end
      default: state_d = PLAY;
    endcase
  end

  always_ff @(posedge pixel_clk) begin
    if (!rst_n) begin
      state_q  <= PLAY;
      scorer_q <= P1;
      winner_q <= P1;
      cnt_q    <= '0;
      s1_q     <= '0;
      s2_q     <= '0;
      inc_q    <= '0;
    end else begin
      state_q  <= state_d;
      scorer_q <= scorer_d;
      winner_q <= winner_d;
      cnt_q    <= cnt_d;
      s1_q     <= s1_d;
      s2_q     <= s2_d;
      inc_q    <= inc_d;
    end
  end

  assign increment_score = inc_q;
  assign round_reset     = (state_q != PLAY);
  assign score_p1        = s1_q;
  assign score_p2        = s2_q;
  assign winner          = winner_q;
`ifdef POINT_JUDGE_WIN_LIMIT_EN
  assign game_over       = (state_q == OVER);
`else
  assign game_over       = 1'b0;
`endif

endmodule

// File: tb/tb_point_judge.sv
// Directed self-checking bench for point_judge (table of frames plus reset/pause sequences).
module tb_point_judge;

  logic               pixel_clk = 1'b0;
  logic               rst_n = 1'b0;
  logic               fsync = 1'b0;
  logic signed [11:0] vpos = '0;
  logic               active_obj = 1'b0;
  logic               active_paddle_p1 = 1'b0;
  logic               active_paddle_p2 = 1'b0;
  logic [1:0]         increment_score;
  logic               round_reset;
  logic               game_over;
  logic               winner;
  logic [3:0]         score_p1;
  logic [3:0]         score_p2;

  int pass_cnt = 0;
  int total_cnt = 0;
  logic [3:0] m_s1 = '0;
  logic [3:0] m_s2 = '0;
  logic go_seen = 1'b0;

  always #5 pixel_clk = ~pixel_clk;

  point_judge #(.VRES(720), .PADDLE_H(20), .WIN_SCORE(7), .RESTART_PAUSE(128)) dut (
    .pixel_clk(pixel_clk), .rst_n(rst_n), .fsync(fsync), .vpos(vpos),
    .active_obj(active_obj), .active_paddle_p1(active_paddle_p1),
    .active_paddle_p2(active_paddle_p2), .increment_score(increment_score),
    .round_reset(round_reset), .game_over(game_over), .winner(winner),
    .score_p1(score_p1), .score_p2(score_p2)
  );

  always @(negedge pixel_clk) if (game_over === 1'b1) go_seen <= 1'b1;

  typedef struct {
    logic [11:0] bline;
    logic        bball;
    logic        bpad;
    logic [11:0] tline;
    logic        tball;
    logic        tpad;
    logic [1:0]  einc;
    logic        err;
  } vec_t;

  vec_t vecs[8];

  task automatic tick();
    @(posedge pixel_clk);
    #1;
  endtask

  task automatic chk(input string name, input logic [31:0] act, input logic [31:0] exp);
    total_cnt++;
    if (act === exp) pass_cnt++;
    else $display("FAIL %s: got %0d expected %0d", name, act, exp);
  endtask

  task automatic frame(input logic [11:0] bl, input logic bb, input logic bp,
                       input logic [11:0] tl, input logic tb, input logic tp);
    vpos = bl; active_obj = bb; active_paddle_p1 = bp; active_paddle_p2 = 1'b0;
    tick();
    vpos = tl; active_obj = tb; active_paddle_p1 = 1'b0; active_paddle_p2 = tp;
    tick();
    vpos = 12'd300; active_obj = 1'b0; active_paddle_p2 = 1'b0;
    tick();
  endtask

  task automatic pulse_fsync();
    fsync = 1'b1;
    tick();
    fsync = 1'b0;
    tick();
  endtask

  task automatic pause_out(input string tag);
    for (int i = 0; i < 127; i++) pulse_fsync();
    chk({tag, "_rr_before_end"}, 32'(round_reset), 32'd1);
    pulse_fsync();
    chk({tag, "_rr_after_end"}, 32'(round_reset), 32'd0);
  endtask

  // fsync edge then the POINT cycle; leaves the bench just after the pulse edge
  task automatic eval_point();
    fsync = 1'b1;
    tick();
    fsync = 1'b0;
    tick();
  endtask

  initial begin
    vecs[0] = '{12'd700, 1'b1, 1'b1, 12'd19, 1'b0, 1'b0, 2'b00, 1'b0};
    vecs[1] = '{12'd700, 1'b1, 1'b0, 12'd19, 1'b0, 1'b0, 2'b10, 1'b1};
    vecs[2] = '{12'd700, 1'b0, 1'b0, 12'd19, 1'b1, 1'b0, 2'b01, 1'b1};
    vecs[3] = '{12'd700, 1'b0, 1'b0, 12'd19, 1'b1, 1'b1, 2'b00, 1'b0};
    vecs[4] = '{12'd700, 1'b1, 1'b0, 12'd19, 1'b1, 1'b0, 2'b00, 1'b1};
    vecs[5] = '{12'd699, 1'b1, 1'b0, 12'd20, 1'b1, 1'b0, 2'b00, 1'b0};
    vecs[6] = '{12'd700, 1'b1, 1'b1, 12'd19, 1'b1, 1'b1, 2'b00, 1'b0};
    vecs[7] = '{12'd700, 1'b1, 1'b0, 12'd19, 1'b1, 1'b1, 2'b10, 1'b1};

    // reset state
    rst_n = 1'b0;
    tick(); tick();
    chk("rst_inc", 32'(increment_score), 32'd0);
    chk("rst_rr", 32'(round_reset), 32'd0);
    chk("rst_go", 32'(game_over), 32'd0);
    chk("rst_winner", 32'(winner), 32'd0);
    chk("rst_s1", 32'(score_p1), 32'd0);
    chk("rst_s2", 32'(score_p2), 32'd0);
    rst_n = 1'b1;
    tick();

    for (int v = 0; v < 8; v++) begin
      frame(vecs[v].bline, vecs[v].bball, vecs[v].bpad, vecs[v].tline, vecs[v].tball, vecs[v].tpad);
      fsync = 1'b1;
      tick();
      fsync = 1'b0;
      chk($sformatf("v%0d_rr", v), 32'(round_reset), 32'(vecs[v].err));
      chk($sformatf("v%0d_inc_early", v), 32'(increment_score), 32'd0);
      tick();
      if (vecs[v].einc[0]) m_s1 = m_s1 + 4'd1;
      if (vecs[v].einc[1]) m_s2 = m_s2 + 4'd1;
      chk($sformatf("v%0d_inc", v), 32'(increment_score), 32'(vecs[v].einc));
      chk($sformatf("v%0d_s1", v), 32'(score_p1), 32'(m_s1));
      chk($sformatf("v%0d_s2", v), 32'(score_p2), 32'(m_s2));
      tick();
      chk($sformatf("v%0d_inc_gone", v), 32'(increment_score), 32'd0);
      if (vecs[v].err) pause_out($sformatf("v%0d", v));
    end

    // misses seen while paused must not score once play resumes
    frame(12'd700, 1'b1, 1'b0, 12'd19, 1'b0, 1'b0);
    eval_point();
    m_s2 = m_s2 + 4'd1;
    chk("disc_s2", 32'(score_p2), 32'(m_s2));
    for (int i = 0; i < 127; i++) pulse_fsync();
    frame(12'd700, 1'b1, 1'b0, 12'd19, 1'b1, 1'b0);
    pulse_fsync();
    chk("disc_rr", 32'(round_reset), 32'd0);
    frame(12'd300, 1'b0, 1'b0, 12'd300, 1'b0, 1'b0);
    eval_point();
    chk("disc_inc", 32'(increment_score), 32'd0);
    chk("disc_s2_hold", 32'(score_p2), 32'(m_s2));

    // reset during the POINT cycle
    frame(12'd700, 1'b1, 1'b0, 12'd19, 1'b0, 1'b0);
    fsync = 1'b1;
    tick();
    fsync = 1'b0;
    rst_n = 1'b0;
    tick();
    rst_n = 1'b1;
    m_s1 = '0; m_s2 = '0;
    chk("rpt_inc", 32'(increment_score), 32'd0);
    chk("rpt_s1", 32'(score_p1), 32'd0);
    chk("rpt_s2", 32'(score_p2), 32'd0);
    chk("rpt_rr", 32'(round_reset), 32'd0);
    tick();
    chk("rpt_inc_after", 32'(increment_score), 32'd0);

    // reset during PAUSE
    frame(12'd700, 1'b1, 1'b0, 12'd19, 1'b1, 1'b0);
    pulse_fsync();
    pulse_fsync(); pulse_fsync();
    chk("rpa_rr_paused", 32'(round_reset), 32'd1);
    rst_n = 1'b0;
    tick();
    rst_n = 1'b1;
    chk("rpa_rr", 32'(round_reset), 32'd0);
    frame(12'd300, 1'b0, 1'b0, 12'd300, 1'b0, 1'b0);
    eval_point();
    chk("rpa_inc", 32'(increment_score), 32'd0);

`ifdef POINT_JUDGE_WIN_LIMIT_EN
    rst_n = 1'b0; tick(); rst_n = 1'b1; tick();
    for (int p = 0; p < 6; p++) begin
      frame(12'd700, 1'b0, 1'b0, 12'd19, 1'b1, 1'b0);
      eval_point();
      tick();
      pause_out($sformatf("win_p%0d", p));
    end
    chk("win_s1_six", 32'(score_p1), 32'd6);
    frame(12'd700, 1'b0, 1'b0, 12'd19, 1'b1, 1'b0);
    eval_point();
    chk("win_inc", 32'(increment_score), 32'd1);
    chk("win_s1", 32'(score_p1), 32'd7);
    tick();
    chk("win_go", 32'(game_over), 32'd1);
    chk("win_winner", 32'(winner), 32'd0);
    for (int i = 0; i < 127; i++) pulse_fsync();
    chk("win_go_held", 32'(game_over), 32'd1);
    pulse_fsync();
    chk("win_go_clr", 32'(game_over), 32'd0);
    chk("win_s1_clr", 32'(score_p1), 32'd0);
    chk("win_s2_clr", 32'(score_p2), 32'd0);
    chk("win_rr_clr", 32'(round_reset), 32'd0);
`else
    rst_n = 1'b0; tick(); rst_n = 1'b1; tick();
    go_seen = 1'b0;
    for (int p = 0; p < 16; p++) begin
      frame(12'd700, 1'b1, 1'b0, 12'd19, 1'b0, 1'b0);
      eval_point();
      if (p == 0) chk("wrap_first", 32'(score_p2), 32'd1);
      if (p == 14) chk("wrap_fifteen", 32'(score_p2), 32'd15);
      tick();
      for (int i = 0; i < 128; i++) pulse_fsync();
    end
    chk("wrap_s2", 32'(score_p2), 32'd0);
    chk("wrap_s1", 32'(score_p1), 32'd0);
    chk("wrap_no_go", 32'(go_seen), 32'd0);
    chk("wrap_rr", 32'(round_reset), 32'd0);
`endif

    $display("%0d/%0d checks passed", pass_cnt, total_cnt);
    $finish;
  end

endmodule

// File: doc/point_judge.md
POINT_JUDGE -- requirements
Module: point_judge

Interface
REQ-001 Parameter VRES, default 720: active lines per frame.
REQ-002 Parameter PADDLE_H, default 20: paddle height in lines; P1 paddle occupies bottom rows, P2 paddle occupies top rows.
REQ-003 Parameter WIN_SCORE, default 7: score that ends the game.
REQ-004 Parameter RESTART_PAUSE, default 128: frames held in pause after a point or game over.
REQ-005 pixel_clk  input  1  pixel clock, sole clock.
REQ-006 rst_n  input  1  reset, synchronous, active-low.
REQ-007 fsync  input  1  one-cycle frame-start pulse.
REQ-008 vpos  input  12 signed  current line.
REQ-009 active_obj  input  1  ball pixel at current position.
REQ-010 active_paddle_p1 / active_paddle_p2  input  1 each  paddle pixel at current position.
REQ-011 increment_score  output  2  one-cycle point pulse; bit0 = P1, bit1 = P2; feeds scoreboard.
REQ-012 round_reset  output  1  high while ball and paddles are held in reset.
REQ-013 game_over  output  1  high during game-over display.
REQ-014 winner  output  1  0 = P1, 1 = P2; valid while game_over.
REQ-015 score_p1 / score_p2  output  4 each  running scores.

Function
REQ-016 Per frame, flags SHALL be captured: bot_seen (active_obj on line VRES-PADDLE_H), bot_hit (active_obj and active_paddle_p1 in the same cycle on that line), top_seen (active_obj on line PADDLE_H-1), top_hit (active_obj and active_paddle_p2 in the same cycle on that line).
REQ-017 Flags SHALL clear on the cycle fsync is sampled. Evaluation SHALL use the flag values held just before the clear.
REQ-018 FSM states SHALL be PLAY, POINT, PAUSE and OVER.
REQ-019 PLAY, evaluated on fsync: bot_seen and not bot_hit -> P2 point; top_seen and not top_hit -> P1 point.
REQ-020 If both players miss in the same frame, neither SHALL score and the FSM SHALL go to PAUSE.
REQ-021 On a point, the FSM SHALL go to POINT. In POINT, the scorer's increment_score bit SHALL pulse for exactly one cycle, and the scorer's score SHALL increment on that same cycle.
REQ-022 Transitions out of POINT, on the next cycle: if the new score equals WIN_SCORE -> OVER, with winner set to the scorer; otherwise -> PAUSE.
REQ-023 PAUSE and OVER SHALL count fsync pulses from 0. After RESTART_PAUSE pulses -> PLAY.
REQ-024 Leaving OVER SHALL also clear both scores.
REQ-025 round_reset SHALL be high in POINT, PAUSE and OVER, and low in PLAY. game_over SHALL be high only in OVER.
REQ-026 Flags captured outside PLAY SHALL be discarded.
REQ-027 Pause counter SHALL be 8 bits wide; RESTART_PAUSE greater than 255 SHALL be rejected at elaboration.
REQ-028 Latency: increment_score pulses 2 cycles after the evaluating fsync (evaluate -> POINT -> pulse registered).

Reset
REQ-029 When rst_n is low at a pixel_clk edge, the following SHALL apply on that edge: state = PLAY, scores = 0, flags = 0, pause counter = 0, increment_score = 0, round_reset = 0, game_over = 0, winner = 0.
REQ-030 Reset mid-POINT SHALL suppress any pending pulse.
REQ-031 Reset mid-PAUSE or mid-OVER SHALL return to PLAY immediately, with no residual pulse.

Configuration
REQ-032 Macro POINT_JUDGE_WIN_LIMIT_EN, when defined: behaviour per REQ-022 and REQ-024.
REQ-033 Without POINT_JUDGE_WIN_LIMIT_EN: OVER SHALL be unreachable, game_over SHALL be tied 0, winner SHALL be tied 0, and scores SHALL wrap modulo 16.

Structure
REQ-034 Shared package pong_pkg SHALL hold:
- state enum (PLAY, POINT, PAUSE, OVER)
- player typedef (P1 = 0, P2 = 1)
- score_t (4 bits)
- default constants WIN_SCORE = 7 and RESTART_PAUSE = 128
REQ-035 Sub-module row_monitor SHALL capture the seen/hit flag pair for one paddle row. It SHALL be instantiated twice, with the row number as a parameter.

Verification
REQ-036 P1 paddle covering the ball on line 700 -> no increment_score, round_reset stays 0.
REQ-037 Ball on line 700 with no P1 paddle overlap -> increment_score = 2'b10 for one cycle, 2 cycles after the next fsync; score_p2 = 1; round_reset high for 128 frames, then low.
REQ-038 Ball on line 19 with P2 paddle absent -> increment_score = 2'b01; score_p1 = 1.
REQ-039 score_p1 = 6, then a P1 point (with POINT_JUDGE_WIN_LIMIT_EN) -> score_p1 = 7, game_over = 1, winner = 0. After 128 fsyncs: game_over = 0, both scores = 0, state PLAY.
REQ-040 rst_n asserted on the POINT cycle -> increment_score stays 0, scores = 0, round_reset = 0 on the next cycle.
REQ-041 Without POINT_JUDGE_WIN_LIMIT_EN: 16 P2 points -> score_p2 wraps to 0, game_over never asserts.
